// File: rtl/half_adder.sv
// Per-lane half adder: sum = in_1 ^ in_2, count (carry) = in_1 & in_2.
// REG_OUT selects registered (1-cycle latency, async reset) or purely combinational outputs.
module half_adder #(
  parameter int unsigned WIDTH   = 1,
  parameter bit          REG_OUT = 1'b1
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic [WIDTH-1:0] in_1,
  input  logic [WIDTH-1:0] in_2,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] sum_next;
  logic [WIDTH-1:0] count_next;

  always_comb begin
    sum_next   = in_1 ^ in_2;
    count_next = in_1 & in_2;
  end

  generate
    if (REG_OUT) begin : g_reg
      always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
          sum   <= '0;
          count <= '0;
        end else begin
          sum   <= sum_next;
          count <= count_next;
        end
      end
    end else begin : g_comb
      // Clock and reset are intentionally ignored in this mode.
      logic unused_clk_rst;
      assign unused_clk_rst = sys_clk ^ sys_rst;
      always_comb begin
        sum   = sum_next;
        count = count_next;
      end
    end
  endgenerate

endmodule

// File: tb/tb_half_adder.sv
// Self-checking bench for half_adder: registered 1-lane, registered 4-lane and combinational instances.
module tb_half_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       rst_c;
  logic       a1, b1, a_c, b_c;
  logic       s1, c1, s_c, c_c;
  logic [3:0] a4, b4, s4, c4;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  half_adder #(.WIDTH(1), .REG_OUT(1'b1)) u_reg1 (
    .sys_clk(clk), .sys_rst(rst), .in_1(a1), .in_2(b1), .sum(s1), .count(c1)
  );

  half_adder #(.WIDTH(4), .REG_OUT(1'b1)) u_reg4 (
    .sys_clk(clk), .sys_rst(rst), .in_1(a4), .in_2(b4), .sum(s4), .count(c4)
  );

  half_adder #(.WIDTH(1), .REG_OUT(1'b0)) u_comb (
    .sys_clk(clk), .sys_rst(rst_c), .in_1(a_c), .in_2(b_c), .sum(s_c), .count(c_c)
  );

  typedef struct packed {
    logic a;
    logic b;
    logic s;
    logic c;
  } vec1_t;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] s;
    logic [3:0] c;
  } vec4_t;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  vec1_t tt[4];
  vec4_t lt[4];

  initial begin
    logic       ea1, eb1;
    logic [3:0] ea4, eb4;

    tt[0] = '{a: 1'b0, b: 1'b0, s: 1'b0, c: 1'b0};
    tt[1] = '{a: 1'b0, b: 1'b1, s: 1'b1, c: 1'b0};
    tt[2] = '{a: 1'b1, b: 1'b0, s: 1'b1, c: 1'b0};
    tt[3] = '{a: 1'b1, b: 1'b1, s: 1'b0, c: 1'b1};

    lt[0] = '{a: 4'b1100, b: 4'b1010, s: 4'b0110, c: 4'b1000};
    lt[1] = '{a: 4'b1111, b: 4'b0000, s: 4'b1111, c: 4'b0000};
    lt[2] = '{a: 4'b0101, b: 4'b0101, s: 4'b0000, c: 4'b0101};
    lt[3] = '{a: 4'b0011, b: 4'b1110, s: 4'b1101, c: 4'b0010};

    rst = 1'b1; rst_c = 1'b1;
    a1 = 1'b1; b1 = 1'b1; a4 = 4'hF; b4 = 4'hF; a_c = 1'b0; b_c = 1'b0;

    // Reset state, held across a clock edge with nonzero inputs
    #3;
    check("rst_s1", {3'b0, s1}, 4'h0);
    check("rst_c1", {3'b0, c1}, 4'h0);
    @(posedge clk); #1;
    check("rst_hold_s1", {3'b0, s1}, 4'h0);
    check("rst_hold_c1", {3'b0, c1}, 4'h0);
    check("rst_hold_s4", s4, 4'h0);
    check("rst_hold_c4", c4, 4'h0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_s1", {3'b0, s1}, 4'h0);
    check("post_rst_c1", {3'b0, c1}, 4'h1);
    check("post_rst_c4", c4, 4'hF);

    // Truth table: registered and combinational (comb held in reset)
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a1 = tt[i].a; b1 = tt[i].b;
      a_c = tt[i].a; b_c = tt[i].b;
      #1;
      check("comb_sum", {3'b0, s_c}, {3'b0, tt[i].s});
      check("comb_cnt", {3'b0, c_c}, {3'b0, tt[i].c});
      @(posedge clk); #1;
      check("tt_sum", {3'b0, s1}, {3'b0, tt[i].s});
      check("tt_cnt", {3'b0, c1}, {3'b0, tt[i].c});
      check("tt_excl", {3'b0, s1 & c1}, 4'h0);
    end

    // Multi-lane independence
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a4 = lt[i].a; b4 = lt[i].b;
      @(posedge clk); #1;
      check("lane_sum", s4, lt[i].s);
      check("lane_cnt", c4, lt[i].c);
    end

    // Async reset between edges with outputs at (0,1)
    @(negedge clk); a1 = 1'b1; b1 = 1'b1;
    @(posedge clk); #1;
    check("pre_async_c1", {3'b0, c1}, 4'h1);
    #2 rst = 1'b1;
    #1;
    check("async_s1", {3'b0, s1}, 4'h0);
    check("async_c1", {3'b0, c1}, 4'h0);
    @(posedge clk); #1;
    check("async_hold_c1", {3'b0, c1}, 4'h0);
    @(negedge clk); rst = 1'b0;
    #2;
    check("released_noedge_c1", {3'b0, c1}, 4'h0);
    @(posedge clk); #1;
    check("release_s1", {3'b0, s1}, 4'h0);
    check("release_c1", {3'b0, c1}, 4'h1);

    // Random soak with intra-cycle input churn and a mid-burst reset pulse
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      a1 = 1'($urandom); b1 = 1'($urandom); a4 = 4'($urandom); b4 = 4'($urandom);
      #2;
      a1 = 1'($urandom); b1 = 1'($urandom); a4 = 4'($urandom); b4 = 4'($urandom);
      rst_c = 1'($urandom);
      a_c = 1'($urandom); b_c = 1'($urandom);
      #1;
      check("soak_comb_sum", {3'b0, s_c}, {3'b0, a_c ^ b_c});
      check("soak_comb_cnt", {3'b0, c_c}, {3'b0, a_c & b_c});
      #1;
      ea1 = 1'($urandom); eb1 = 1'($urandom); ea4 = 4'($urandom); eb4 = 4'($urandom);
      a1 = ea1; b1 = eb1; a4 = ea4; b4 = eb4;
      @(posedge clk); #1;
      check("soak_s1", {3'b0, s1}, {3'b0, ea1 ^ eb1});
      check("soak_c1", {3'b0, c1}, {3'b0, ea1 & eb1});
      check("soak_s4", s4, ea4 ^ eb4);
      check("soak_c4", c4, ea4 & eb4);
      if (i == 500) begin
        rst = 1'b1;
        #1;
        check("burst_rst_s4", s4, 4'h0);
        check("burst_rst_c4", c4, 4'h0);
        check("burst_rst_s1", {3'b0, s1}, 4'h0);
        #2 rst = 1'b0;
        check("burst_rel_s4", s4, 4'h0);
        check("burst_rel_c4", c4, 4'h0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/half_adder.md
Name: half_adder

Overview:
- Single-bit (per lane) half adder: sum = in_1 XOR in_2, count (carry) = in_1 AND in_2.
- Leaf arithmetic cell used as the building block for full adders and ripple adders in the design.
- Outputs are registered on sys_clk by default. A combinational mode is selectable by parameter.
- Parameterised for N independent bit lanes, so one instance can serve a vector of half adds.

Parameters:
- WIDTH, 1, number of independent half-adder lanes; legal range 1 to 64.
- REG_OUT, 1, 1 means outputs are registered (latency 1 clock); 0 means outputs are purely combinational from the inputs (latency 0; clock and reset unused).

Ports:
- sys_clk  input  1  system clock, rising-edge active.
- sys_rst  input  1  asynchronous, active-high reset.
- in_1  input  WIDTH  addend A, one bit per lane.
- in_2  input  WIDTH  addend B, one bit per lane.
- sum  output  WIDTH  per-lane sum bit, in_1[i] XOR in_2[i].
- count  output  WIDTH  per-lane carry-out bit, in_1[i] AND in_2[i].

Interface notes:
- One clock; reset is asynchronous and active-high.
- Clock and reset are named sys_clk and sys_rst.
- No handshake. Inputs are sampled every cycle.

Behaviour:
- Per lane i, independent of all other lanes: {count[i], sum[i]} = in_1[i] + in_2[i].
  - Result is 2 bits wide, with no overflow possible.
- Truth table per lane (in_1, in_2 -> sum, count):
  - 0,0 -> 0,0
  - 0,1 -> 1,0
  - 1,0 -> 1,0
  - 1,1 -> 0,1
- sum and count are never both 1 in the same lane.
- REG_OUT=1:
  - On each rising sys_clk edge, sum and count load the function of the in_1/in_2 values present just before that edge.
  - Latency is exactly 1 clock. Throughput is one result per clock.
- REG_OUT=1 reset:
  - sys_rst high immediately forces sum=0 and count=0 (all lanes), without waiting for a clock edge.
  - Outputs hold 0 for as long as sys_rst is high.
  - On the first rising edge after sys_rst is deasserted, outputs load the current inputs.
- REG_OUT=1, reset asserted mid-operation: outputs clear immediately and the in-flight result is discarded. No residual state exists.
- REG_OUT=0:
  - sum and count follow in_1/in_2 combinationally, with zero latency.
  - sys_rst and sys_clk have no effect.
- Inputs that change several times between clock edges (REG_OUT=1): only the value at the sampling edge matters, with no glitch propagation to the outputs.
- X/Z on an input lane propagates only to that lane. Other lanes are unaffected.
- No internal state other than the output registers. No FSM.

Test Plan:
- Reset: with REG_OUT=1, WIDTH=1, apply in_1=1, in_2=1 and assert sys_rst asynchronously between clock edges. Required: sum=0, count=0 immediately, holding 0 while reset is high. After release, the next rising edge gives sum=0, count=1.
- Exhaustive truth table: with WIDTH=1, REG_OUT=1, drive 00, 01, 10, 11 on successive cycles. Required one cycle later for each: (0,0), (1,0), (1,0), (0,1). Also required: sum&count is never 1.
- Random soak: with WIDTH=1, randomise in_1 and in_2 every 10 ns for at least 1000 cycles. Required: every registered output equals the reference model of the previous cycle's inputs.
- Multi-lane independence: with WIDTH=4, drive in_1=4'b1100, in_2=4'b1010. Required one cycle later: sum=4'b0110, count=4'b1000. Then drive in_1=4'b1111, in_2=4'b0000; required: sum=4'b1111, count=4'b0000.
- Combinational mode: with REG_OUT=0, WIDTH=1, toggle the inputs through all four combinations while holding sys_rst=1. Required: outputs match the truth table with zero delay, and reset is ignored.
- Mid-burst reset: with REG_OUT=1, stream the random inputs and pulse sys_rst for 3 ns inside a clock period. Required: outputs read 0 from the pulse until the next edge, then track the inputs correctly from that edge onward.
